// File: rtl/eeprom_pkg.sv
// eeprom_pkg: shared constants, state type and helpers for the I2C EEPROM
// write/read sequencer.
package eeprom_pkg;

  // Word-address width (array depth 2**ADDR_W).
  localparam int ADDR_W     = 8;
  // In-page offset width and resulting page size in bytes.
  localparam int PAGE_W     = 3;
  localparam int PAGE_BYTES = 2**PAGE_W;

  // Sequencer states.
  typedef enum logic [2:0] {
    IDLE,
    GET_ADDR,
    WR_DATA,
    COMMIT,
    TWR,
    RD_DATA
  } state_e;

  // Width of a down-counter that must hold values 0..twr_cycles.
  function automatic int twr_cnt_w(input int twr_cycles);
    return $clog2(twr_cycles + 1);
  endfunction

endpackage

// File: rtl/eeprom_addr_cnt.sv
// eeprom_addr_cnt: the EEPROM word-address counter, kept as a {page, cnt} pair.
// Page writes advance only cnt (wrapping inside the page); sequential reads
// advance the whole address (wrapping at the top of the array).
module eeprom_addr_cnt #(
  parameter int ADDR_W = eeprom_pkg::ADDR_W,
  parameter int PAGE_W = eeprom_pkg::PAGE_W
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              load,
  input  logic [ADDR_W-1:0] load_val,
  input  logic              inc_page,
  input  logic              inc_full,
  output logic [ADDR_W-1:0] addr
);
  import eeprom_pkg::*;

  logic [ADDR_W-PAGE_W-1:0] page_q, page_d;
  logic [PAGE_W-1:0]        cnt_q,  cnt_d;

  // Next address: load has priority, then whole-array increment, then in-page increment.
  always_comb begin
    // NOTE: every variable gets a default before any branch, so no path leaves it
    // unassigned and no latch is inferred.
    page_d = page_q;
    cnt_d  = cnt_q;
    if (load) begin
      {page_d, cnt_d} = load_val;
    end else if (inc_full) begin
      {page_d, cnt_d} = {page_q, cnt_q} + ADDR_W'(1);
    end else if (inc_page) begin
      cnt_d = cnt_q + PAGE_W'(1);
    end
  end

  // Address register with synchronous reset to word 0.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every flop samples
    // the pre-edge values regardless of block ordering.
    if (reset) begin
      page_q <= '0;
      cnt_q  <= '0;
    end else begin
      page_q <= page_d;
      cnt_q  <= cnt_d;
    end
  end

  assign addr = {page_q, cnt_q};

endmodule

// File: rtl/eeprom_wr_ctrl.sv
// eeprom_wr_ctrl: write/read sequencer between the I2C byte engine and the
// 256x8 EEPROM array. Buffers one page of write data, commits it after STOP
// in ascending offset order, holds off the bus for the write-cycle time, and
// serves current-address / sequential reads.
module eeprom_wr_ctrl #(
  parameter int ADDR_W     = eeprom_pkg::ADDR_W,
  parameter int PAGE_W     = eeprom_pkg::PAGE_W,
  parameter int TWR_CYCLES = 1000
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              txn_start,
  input  logic              txn_rw,
  input  logic              txn_stop,
  input  logic              wr_byte_valid,
  input  logic [7:0]        wr_byte,
  input  logic              rd_byte_req,
  output logic [7:0]        rd_byte,
  output logic              rd_byte_valid,
  output logic              busy,
  output logic [ADDR_W-1:0] mem_addr,
  output logic              mem_we,
  output logic [7:0]        mem_wdata,
  output logic              mem_re,
  input  logic [7:0]        mem_rdata
);
  import eeprom_pkg::*;

  localparam int BUF_DEPTH = 2**PAGE_W;
  localparam int TWR_CW    = twr_cnt_w(TWR_CYCLES);
  localparam logic [TWR_CW-1:0] TWR_LOAD = TWR_CW'(TWR_CYCLES - 1);

  // Lowest set bit of a byte-valid mask; commits go out in ascending offset order.
  function automatic logic [PAGE_W-1:0] first_set(input logic [BUF_DEPTH-1:0] mask);
    logic [PAGE_W-1:0] idx;
    idx = '0;
    for (int i = BUF_DEPTH - 1; i >= 0; i--) begin
      if (mask[i]) idx = PAGE_W'(i);
    end
    return idx;
  endfunction

  // A START (or repeated START) picks the next state from the R/W bit alone.
  function automatic state_e start_target(input logic rw);
    return rw ? RD_DATA : GET_ADDR;
  endfunction

  state_e                state_q, state_d;
  logic [BUF_DEPTH-1:0]  vmask_q, vmask_d;
  logic [7:0]            pbuf_q [BUF_DEPTH];
  logic [7:0]            pbuf_d [BUF_DEPTH];
  logic [TWR_CW-1:0]     twr_cnt_q, twr_cnt_d;

  logic                  mem_we_q, mem_we_d;
  logic                  mem_re_q, mem_re_d;
  logic [ADDR_W-1:0]     mem_addr_q, mem_addr_d;
  logic [7:0]            mem_wdata_q, mem_wdata_d;
  logic                  rd_byte_valid_q, rd_byte_valid_d;
  logic                  busy_q, busy_d;

  logic                  ac_load;
  logic                  ac_inc_page;
  logic                  ac_inc_full;
  logic [ADDR_W-1:0]     ac_addr;
  logic [ADDR_W-PAGE_W-1:0] ac_page;
  logic [PAGE_W-1:0]     ac_cnt;

  logic                  do_issue;
  logic [PAGE_W-1:0]     issue_idx;

  assign ac_page = ac_addr[ADDR_W-1:PAGE_W];
  assign ac_cnt  = ac_addr[PAGE_W-1:0];

  // A read issued last cycle moves the address on as its data comes back.
  assign ac_inc_full = mem_re_q;

  eeprom_addr_cnt #(
    .ADDR_W (ADDR_W),
    .PAGE_W (PAGE_W)
  ) u_addr_cnt (
    .clk      (clk),
    .reset    (reset),
    .load     (ac_load),
    .load_val (wr_byte),
    .inc_page (ac_inc_page),
    .inc_full (ac_inc_full),
    .addr     (ac_addr)
  );

  // Next-state, buffer and registered-output computation for the sequencer.
  always_comb begin
    state_d         = state_q;
    vmask_d         = vmask_q;
    pbuf_d          = pbuf_q;
    twr_cnt_d       = twr_cnt_q;
    mem_we_d        = 1'b0;
    mem_re_d        = 1'b0;
    mem_addr_d      = '0;
    mem_wdata_d     = '0;
    rd_byte_valid_d = mem_re_q;
    ac_load         = 1'b0;
    ac_inc_page     = 1'b0;
    do_issue        = 1'b0;
    issue_idx       = '0;

    unique case (state_q)
      IDLE: begin
        if (txn_start) state_d = start_target(txn_rw);
      end

      GET_ADDR: begin
        if (txn_start) begin
          state_d = start_target(txn_rw);
        end else begin
          if (wr_byte_valid) begin
            ac_load = 1'b1;
            state_d = WR_DATA;
          end
          if (txn_stop) state_d = IDLE;
        end
      end

      WR_DATA: begin
        if (txn_start) begin
          // Repeated START abandons the page: nothing buffered is committed.
          vmask_d = '0;
          state_d = start_target(txn_rw);
        end else begin
          if (wr_byte_valid) begin
            pbuf_d[ac_cnt]  = wr_byte;
            vmask_d[ac_cnt] = 1'b1;
            ac_inc_page     = 1'b1;
          end
          if (txn_stop) begin
            // A byte arriving with STOP is already folded into vmask_d/pbuf_d,
            // so the first commit write can leave on the next edge.
            if (vmask_d != '0) begin
              state_d  = COMMIT;
              do_issue = 1'b1;
            end else begin
              state_d = IDLE;
            end
          end
        end
      end

      COMMIT: begin
        if (vmask_q != '0) begin
          do_issue = 1'b1;
        end else begin
          state_d   = TWR;
          twr_cnt_d = TWR_LOAD;
        end
      end

      TWR: begin
        vmask_d = '0;
        if (twr_cnt_q == '0) begin
          state_d = IDLE;
        end else begin
          twr_cnt_d = twr_cnt_q - TWR_CW'(1);
        end
      end

      RD_DATA: begin
        if (txn_start) begin
          state_d = start_target(txn_rw);
        end else if (txn_stop) begin
          state_d = IDLE;
        end else if (rd_byte_req && !mem_re_q) begin
          mem_re_d   = 1'b1;
          mem_addr_d = ac_addr;
        end
      end

      default: state_d = IDLE;
    endcase

    // One page-buffer entry per cycle goes to the array, lowest offset first.
    if (do_issue) begin
      issue_idx          = first_set(vmask_d);
      mem_we_d           = 1'b1;
      mem_addr_d         = {ac_page, issue_idx};
      mem_wdata_d        = pbuf_d[issue_idx];
      vmask_d[issue_idx] = 1'b0;
    end

    busy_d = (state_d == COMMIT) || (state_d == TWR);
  end

  // Sequencer state and all output registers, synchronous reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q         <= IDLE;
      vmask_q         <= '0;
      twr_cnt_q       <= '0;
      mem_we_q        <= 1'b0;
      mem_re_q        <= 1'b0;
      mem_addr_q      <= '0;
      mem_wdata_q     <= '0;
      rd_byte_valid_q <= 1'b0;
      busy_q          <= 1'b0;
    end else begin
      state_q         <= state_d;
      vmask_q         <= vmask_d;
      twr_cnt_q       <= twr_cnt_d;
      mem_we_q        <= mem_we_d;
      mem_re_q        <= mem_re_d;
      mem_addr_q      <= mem_addr_d;
      mem_wdata_q     <= mem_wdata_d;
      rd_byte_valid_q <= rd_byte_valid_d;
      busy_q          <= busy_d;
    end
  end

  // Page buffer storage.
  always_ff @(posedge clk) begin
    // NOTE: the page buffer is deliberately not reset; vmask marks which entries
    // are meaningful, so stale contents are never committed.
    pbuf_q <= pbuf_d;
  end

  assign mem_we        = mem_we_q;
  assign mem_re        = mem_re_q;
  assign mem_addr      = mem_addr_q;
  assign mem_wdata     = mem_wdata_q;
  assign rd_byte_valid = rd_byte_valid_q;
  assign busy          = busy_q;
  // mem_rdata comes straight from the array's output register; it is only
  // forwarded while the matching valid pulse is high.
  assign rd_byte       = rd_byte_valid_q ? mem_rdata : 8'h00;

endmodule

// File: tb/tb_eeprom_wr_ctrl.sv
// tb_eeprom_wr_ctrl: directed bench for eeprom_wr_ctrl with a transaction-level
// model (page arithmetic + golden array) compared against the DUT every cycle.
module tb_eeprom_wr_ctrl;

  localparam int TWR = 12;

  logic       clk = 1'b0;
  logic       reset;
  logic       txn_start, txn_rw, txn_stop, wr_byte_valid, rd_byte_req;
  logic [7:0] wr_byte;
  logic [7:0] rd_byte;
  logic       rd_byte_valid, busy, mem_we, mem_re;
  logic [7:0] mem_addr, mem_wdata, mem_rdata;

  eeprom_wr_ctrl #(
    .ADDR_W     (8),
    .PAGE_W     (3),
    .TWR_CYCLES (TWR)
  ) dut (
    .clk           (clk),
    .reset         (reset),
    .txn_start     (txn_start),
    .txn_rw        (txn_rw),
    .txn_stop      (txn_stop),
    .wr_byte_valid (wr_byte_valid),
    .wr_byte       (wr_byte),
    .rd_byte_req   (rd_byte_req),
    .rd_byte       (rd_byte),
    .rd_byte_valid (rd_byte_valid),
    .busy          (busy),
    .mem_addr      (mem_addr),
    .mem_we        (mem_we),
    .mem_wdata     (mem_wdata),
    .mem_re        (mem_re),
    .mem_rdata     (mem_rdata)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s cyc=%0d got=%0h expected=%0h", name, cyc, act, exp);
    end
  endtask

  function automatic logic [7:0] init_val(input int a);
    return 8'(a) ^ 8'h5A;
  endfunction

  // Array model seen by the DUT: registered read data, one cycle after mem_re.
  logic [7:0] mem [256];
  logic       mem_init;
  always @(posedge clk) begin
    if (mem_init) begin
      for (int i = 0; i < 256; i++) mem[i] <= init_val(i);
    end else if (mem_we === 1'b1) begin
      mem[mem_addr] <= mem_wdata;
    end
    if (mem_re === 1'b1) mem_rdata <= mem[mem_addr];
  end

  // Reference model: golden array contents, word-address pointer, and the
  // cycle-by-cycle schedule of expected strobes derived from each transaction.
  logic [7:0]  gold [256];
  int          ptr = 0;
  logic [15:0] we_sched [int];
  logic [7:0]  re_sched [int];
  logic [7:0]  rv_sched [int];
  int          busy_lo = 0, busy_hi = 0, twr_start = 0;
  bit          run_chk = 1'b0;
  int          busy_cnt = 0, we_cnt = 0;
  logic [7:0]  rd_log [$];

  // Per-cycle comparison of every DUT output against the model schedule.
  always @(negedge clk) begin
    bit          e_we, e_re, e_rv, e_busy;
    logic [15:0] w;
    if (run_chk) begin
      e_we   = (we_sched.exists(cyc) != 0);
      e_re   = (re_sched.exists(cyc) != 0);
      e_rv   = (rv_sched.exists(cyc) != 0);
      e_busy = (cyc >= busy_lo) && (cyc < busy_hi);
      check("busy", 32'(busy), 32'(e_busy));
      check("mem_we", 32'(mem_we), 32'(e_we));
      check("mem_re", 32'(mem_re), 32'(e_re));
      check("rd_byte_valid", 32'(rd_byte_valid), 32'(e_rv));
      if (e_we) begin
        w = we_sched[cyc];
        check("we_addr", 32'(mem_addr), 32'(w[15:8]));
        check("we_data", 32'(mem_wdata), 32'(w[7:0]));
      end
      if (e_re) check("re_addr", 32'(mem_addr), 32'(re_sched[cyc]));
      if (e_rv) check("rd_byte", 32'(rd_byte), 32'(rv_sched[cyc]));
      if (busy === 1'b1) busy_cnt++;
      if (mem_we === 1'b1) we_cnt++;
      if (rd_byte_valid === 1'b1) rd_log.push_back(rd_byte);
    end
  end

  function automatic logic [7:0] rd_at(input int i);
    return (i < rd_log.size()) ? rd_log[i] : 8'hxx;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Holds the given input pattern for exactly one cycle, then returns all pulses low.
  task automatic drive(input bit st, input bit rw, input bit sp, input bit wv,
                       input logic [7:0] wb, input bit rq);
    txn_start = st; txn_rw = rw; txn_stop = sp;
    wr_byte_valid = wv; wr_byte = wb; rd_byte_req = rq;
    tick();
    txn_start = 1'b0; txn_stop = 1'b0; wr_byte_valid = 1'b0; rd_byte_req = 1'b0;
  endtask

  // Full write transaction: n bytes first, first+step, ...; optionally the last
  // byte shares its cycle with STOP. Model applies in-page wrap and ascending commit.
  task automatic do_write(input logic [7:0] addr, input logic [7:0] first,
                          input logic [7:0] step, input int n, input bit stop_with_last);
    logic [7:0] pb [8];
    bit         pv [8];
    logic [7:0] b;
    int         base, off, k, n_stop;
    base = int'(addr) & 'hF8;
    off  = int'(addr) & 7;
    for (int i = 0; i < 8; i++) begin pv[i] = 1'b0; pb[i] = 8'h00; end
    drive(1, 0, 0, 0, 8'h00, 0);
    drive(0, 0, 0, 1, addr, 0);
    n_stop = 0;
    b = first;
    for (int j = 0; j < n; j++) begin
      pb[off] = b;
      pv[off] = 1'b1;
      if (stop_with_last && j == n - 1) begin
        n_stop = cyc;
        drive(0, 0, 1, 1, b, 0);
      end else begin
        drive(0, 0, 0, 1, b, 0);
      end
      off = (off + 1) % 8;
      b   = b + step;
    end
    if (!stop_with_last) begin
      n_stop = cyc;
      drive(0, 0, 1, 0, 8'h00, 0);
    end
    k = 0;
    for (int i = 0; i < 8; i++) begin
      if (pv[i]) begin
        we_sched[n_stop + 1 + k] = {8'(base + i), pb[i]};
        gold[base + i] = pb[i];
        k++;
      end
    end
    busy_lo   = n_stop + 1;
    twr_start = n_stop + 1 + k;
    busy_hi   = n_stop + 1 + k + TWR;
    ptr       = base + off;
  endtask

  // n read requests, each spaced past its data return.
  task automatic do_reads(input int n);
    for (int j = 0; j < n; j++) begin
      re_sched[cyc + 1] = 8'(ptr);
      rv_sched[cyc + 2] = gold[ptr];
      drive(0, 0, 0, 0, 8'h00, 1);
      tick();
      tick();
      ptr = (ptr + 1) % 256;
    end
  endtask

  task automatic read_txn(input int n);
    drive(1, 1, 0, 0, 8'h00, 0);
    do_reads(n);
    drive(0, 0, 1, 0, 8'h00, 0);
  endtask

  task automatic wait_idle();
    while (cyc <= busy_hi) tick();
  endtask

  task automatic check_outputs_zero(input string tag);
    check({tag, "_busy"}, 32'(busy), 32'd0);
    check({tag, "_mem_we"}, 32'(mem_we), 32'd0);
    check({tag, "_mem_re"}, 32'(mem_re), 32'd0);
    check({tag, "_mem_addr"}, 32'(mem_addr), 32'd0);
    check({tag, "_mem_wdata"}, 32'(mem_wdata), 32'd0);
    check({tag, "_rd_valid"}, 32'(rd_byte_valid), 32'd0);
    check({tag, "_rd_byte"}, 32'(rd_byte), 32'd0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog cyc=%0d got=timeout expected=finish", cyc);
    $fatal(1, "watchdog expired");
  end

  initial begin
    int we0, mis, r;
    reset = 1'b1; mem_init = 1'b1;
    txn_start = 1'b0; txn_rw = 1'b0; txn_stop = 1'b0;
    wr_byte_valid = 1'b0; wr_byte = 8'h00; rd_byte_req = 1'b0;
    for (int i = 0; i < 256; i++) gold[i] = init_val(i);
    repeat (3) tick();
    check_outputs_zero("reset");
    reset = 1'b0; mem_init = 1'b0;
    run_chk = 1'b1;
    tick();

    // Two-byte write at 0x13; START/req/byte while busy must be ignored.
    busy_cnt = 0;
    do_write(8'h13, 8'hAA, 8'h11, 2, 1'b0);
    while (cyc < twr_start + 2) tick();
    drive(1, 1, 0, 0, 8'h00, 0);
    drive(0, 0, 0, 0, 8'h00, 1);
    drive(0, 0, 0, 1, 8'h77, 0);
    wait_idle();
    check("t1_busy_len", 32'(busy_cnt), 32'(2 + TWR));
    check("t1_mem13", 32'(mem[8'h13]), 32'hAA);
    check("t1_mem14", 32'(mem[8'h14]), 32'hBB);
    rd_log.delete();
    read_txn(1);
    check("t1_cur_read", 32'(rd_at(0)), 32'h4F);

    // In-page wrap from 0x1E, last byte arrives together with STOP.
    do_write(8'h1E, 8'h01, 8'h01, 4, 1'b1);
    wait_idle();
    check("t2_mem18", 32'(mem[8'h18]), 32'h03);
    check("t2_mem19", 32'(mem[8'h19]), 32'h04);
    check("t2_mem1e", 32'(mem[8'h1E]), 32'h01);
    check("t2_mem1f", 32'(mem[8'h1F]), 32'h02);
    check("t2_mem1a", 32'(mem[8'h1A]), 32'h40);

    // Ten bytes into one page: only eight writes, later bytes win.
    we0 = we_cnt;
    do_write(8'h00, 8'h00, 8'h01, 10, 1'b0);
    wait_idle();
    check("t3_we_count", 32'(we_cnt - we0), 32'd8);
    check("t3_mem00", 32'(mem[8'h00]), 32'h08);
    check("t3_mem01", 32'(mem[8'h01]), 32'h09);
    check("t3_mem07", 32'(mem[8'h07]), 32'h07);

    // Dummy write to 0xFE, repeated START as read, roll-over through 0xFF.
    we0 = we_cnt;
    rd_log.delete();
    drive(1, 0, 0, 0, 8'h00, 0);
    drive(0, 0, 0, 1, 8'hFE, 0);
    ptr = 'hFE;
    drive(1, 1, 0, 0, 8'h00, 0);
    do_reads(3);
    drive(0, 0, 1, 0, 8'h00, 0);
    tick();
    check("t4_rd_count", 32'(rd_log.size()), 32'd3);
    check("t4_rd0", 32'(rd_at(0)), 32'hA4);
    check("t4_rd1", 32'(rd_at(1)), 32'hA5);
    check("t4_rd2", 32'(rd_at(2)), 32'h08);
    check("t4_no_we", 32'(we_cnt - we0), 32'd0);

    // Reset five cycles into the write-cycle wait.
    do_write(8'h40, 8'h11, 8'h11, 2, 1'b0);
    while (cyc < twr_start + 5) tick();
    r       = cyc;
    busy_hi = r + 1;
    ptr     = 0;
    reset   = 1'b1;
    tick();
    reset   = 1'b0;
    check_outputs_zero("twr_reset");
    check("t5_mem40", 32'(mem[8'h40]), 32'h11);
    rd_log.delete();
    read_txn(1);
    check("t5_read0", 32'(rd_at(0)), 32'h08);

    // Whole-array comparison against the golden image.
    tick();
    mis = 0;
    for (int i = 0; i < 256; i++) if (mem[i] !== gold[i]) mis++;
    check("array_image", 32'(mis), 32'd0);

    run_chk = 1'b0;
    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
